// File: rtl/msd_pkg.sv
// Shared types and constants for the DDR5 DIMM scheduler front end.
package msd_pkg;

    localparam int MSD_QDEPTH = 16;
    localparam int MSD_NCORES = 12;

    typedef enum logic [1:0] {
        OP_RD = 2'd0,
        OP_WR = 2'd1,
        OP_IF = 2'd2
    } mem_op_t;

    typedef struct packed {
        logic [15:0] row;
        logic [9:0]  col;
        logic [1:0]  bank;
        logic [2:0]  bg;
    } dram_addr_t;

    // One queue slot: the op plus the already-decoded DRAM coordinates.
    typedef struct packed {
        mem_op_t    op;
        dram_addr_t fields;
    } entry_t;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_state_t;

endpackage

// File: rtl/msd_addr_decode.sv
// Splits a 36-bit physical byte address into DRAM row/col/bank/bank-group
// and flags addresses outside the single populated channel.
module msd_addr_decode
    import msd_pkg::*;
(
    input  logic [35:0] addr,
    output dram_addr_t  fields,
    output logic        legal
);

    // The low two bits select bytes within a 32-bit beat and carry no DRAM field.
    logic unused_byte_bits;
    assign unused_byte_bits = ^addr[1:0];

    assign fields.row  = addr[33:18];
    assign fields.col  = {addr[17:12], addr[5:2]};
    assign fields.bank = addr[11:10];
    assign fields.bg   = addr[9:7];

    assign legal = (addr[35:34] == 2'b00) && (addr[6] == 1'b0);

endmodule

// File: rtl/msd_req_queue.sv
// In-order request queue in front of the DDR5 command scheduler: drops illegal
// requests with a one-cycle error pulse and presents the decoded head entry.
module msd_req_queue
    import msd_pkg::*;
#(
    parameter int DEPTH = MSD_QDEPTH,
    parameter int AGE_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [11:0]            in_core,
    input  logic [1:0]             in_op,
    input  logic [35:0]            in_addr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [1:0]             out_op,
    output logic [15:0]            out_row,
    output logic [9:0]             out_col,
    output logic [1:0]             out_bank,
    output logic [2:0]             out_bg,
    output logic [AGE_W-1:0]       out_age,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   err_illegal,
    output logic [1:0]             occ_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // in_ready and out_valid depend only on occupancy, never on the partner's
    // signal, so a full queue cannot pass through and an empty one cannot bypass.

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    occ_state_t       state;
    occ_state_t       state_nxt;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    entry_t           mem [DEPTH];
    logic [AGE_W-1:0] age [DEPTH];
    logic [DEPTH-1:0] occupied;
    entry_t           head;

    dram_addr_t in_fields;
    logic       addr_legal;
    logic       in_legal;
    logic       offer;
    logic       push;
    logic       pop;

    msd_addr_decode u_decode (
        .addr   (in_addr),
        .fields (in_fields),
        .legal  (addr_legal)
    );

    assign in_legal = (in_op <= 2'(OP_IF)) && (in_core < 12'(MSD_NCORES)) && addr_legal;

    assign full      = (state == OCC_FULL);
    assign empty     = (state == OCC_EMPTY);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign occ_state = state;

    // An illegal offer still completes the handshake so the source moves on.
    assign offer = in_valid && in_ready;
    assign push  = offer && in_legal;
    assign pop   = out_valid && out_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            OCC_EMPTY: begin
                if (push) state_nxt = OCC_PARTIAL;
            end
            OCC_PARTIAL: begin
                if (push && !pop && count == CNT_W'(DEPTH - 1)) begin
                    state_nxt = OCC_FULL;
                end else if (pop && !push && count == CNT_W'(1)) begin
                    state_nxt = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (pop) state_nxt = OCC_PARTIAL;
            end
            default: state_nxt = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= OCC_EMPTY;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            err_illegal <= 1'b0;
        end else begin
            state       <= state_nxt;
            err_illegal <= offer && !in_legal;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset: it is only visible through out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{op: mem_op_t'(in_op), fields: in_fields};
        end
    end

    // A slot can never be pushed and popped on the same edge: that would need
    // the queue to be both empty (pop ignored) and full (push refused).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupied <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                age[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push && wr_ptr == PTR_W'(i)) begin
                    occupied[i] <= 1'b1;
                    age[i]      <= '0;
                end else begin
                    if (pop && rd_ptr == PTR_W'(i)) occupied[i] <= 1'b0;
                    if (occupied[i] && age[i] != '1) age[i] <= age[i] + AGE_W'(1);
                end
            end
        end
    end

    assign head = mem[rd_ptr];

    assign out_op   = out_valid ? 2'(head.op)       : 2'b00;
    assign out_row  = out_valid ? head.fields.row  : '0;
    assign out_col  = out_valid ? head.fields.col  : '0;
    assign out_bank = out_valid ? head.fields.bank : '0;
    assign out_bg   = out_valid ? head.fields.bg   : '0;
    assign out_age  = out_valid ? age[rd_ptr]      : '0;

endmodule

// File: tb/tb_msd_req_queue.sv
// Self-checking bench for msd_req_queue: directed corner cases plus random
// traffic, checked against an ordered list of accepted requests.
module tb_msd_req_queue;

    localparam int DEPTH   = 16;
    localparam int AGE_MAX = 255;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_core;
    logic [1:0]  in_op;
    logic [35:0] in_addr;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_op;
    logic [15:0] out_row;
    logic [9:0]  out_col;
    logic [1:0]  out_bank;
    logic [2:0]  out_bg;
    logic [7:0]  out_age;
    logic [4:0]  count;
    logic        full;
    logic        empty;
    logic        err_illegal;
    logic [1:0]  occ_state;

    msd_req_queue #(.DEPTH(DEPTH), .AGE_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_core     (in_core),
        .in_op       (in_op),
        .in_addr     (in_addr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_op      (out_op),
        .out_row     (out_row),
        .out_col     (out_col),
        .out_bank    (out_bank),
        .out_bg      (out_bg),
        .out_age     (out_age),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .err_illegal (err_illegal),
        .occ_state   (occ_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [37:0] exp_q[$];   // {op, addr} of every accepted request, oldest first
    int          push_q[$];  // cycle number at which each entry was accepted
    int          cyc = 0;
    logic        err_exp = 1'b0;
    int          n_vec = 0;
    int          n_bad = 0;

    function automatic bit ref_legal(input logic [1:0] op, input logic [11:0] core,
                                     input logic [35:0] a);
        return (op != 2'd3) && (core < 12'd12) && (a[6] == 1'b0) && (a[35:34] == 2'b00);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stimulus side: decide from the queue's own occupancy what the DUT must do.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            push_q.delete();
            err_exp = 1'b0;
            cyc     = 0;
        end else begin
            bit can_take;
            bit legal;
            cyc++;
            can_take = exp_q.size() < DEPTH;
            legal    = ref_legal(in_op, in_core, in_addr);
            err_exp  = in_valid && can_take && !legal;
            if (out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                void'(push_q.pop_front());
            end
            if (in_valid && can_take && legal) begin
                exp_q.push_back({in_op, in_addr});
                push_q.push_back(cyc);
            end
        end
    end

    // Monitor: compare everything the DUT presents against the oldest entry.
    always @(negedge clk) begin
        int          n;
        logic [35:0] a;
        int          exp_age;
        n = exp_q.size();
        check("count",       64'(count),       64'(n));
        check("empty",       64'(empty),       64'(n == 0));
        check("full",        64'(full),        64'(n == DEPTH));
        check("in_ready",    64'(in_ready),    64'(n < DEPTH));
        check("out_valid",   64'(out_valid),   64'(n > 0));
        check("err_illegal", 64'(err_illegal), 64'(err_exp));
        if (n > 0) begin
            a = exp_q[0][35:0];
            exp_age = cyc - push_q[0];
            if (exp_age > AGE_MAX) exp_age = AGE_MAX;
            check("out_op",   64'(out_op),   64'(exp_q[0][37:36]));
            check("out_row",  64'(out_row),  64'((a >> 18) & 36'hFFFF));
            check("out_col",  64'(out_col),  64'((((a >> 12) & 36'h3F) << 4) | ((a >> 2) & 36'hF)));
            check("out_bank", 64'(out_bank), 64'((a >> 10) & 36'h3));
            check("out_bg",   64'(out_bg),   64'((a >> 7) & 36'h7));
            check("out_age",  64'(out_age),  64'(exp_age));
        end else begin
            check("idle_data", 64'({out_op, out_row, out_col, out_bank, out_bg, out_age}), 64'(0));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [1:0] op, input logic [11:0] core,
                         input logic [35:0] addr, input logic rdy);
        in_valid  = v;
        in_op     = op;
        in_core   = core;
        in_addr   = addr;
        out_ready = rdy;
        @(negedge clk);
        #1;
    endtask

    function automatic logic [35:0] rand_addr();
        logic [35:0] a;
        a = {4'($urandom), 32'($urandom)};
        a[35:34] = 2'b00;
        a[6]     = 1'b0;
        return a;
    endfunction

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) drive(1'b0, 2'd0, 12'd0, 36'd0, 1'b0);
    endtask

    task automatic push_legal(input logic rdy);
        drive(1'b1, 2'($urandom_range(0, 2)), 12'($urandom_range(0, 11)), rand_addr(), rdy);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 4; i++) begin
            if (exp_q.size() == 0) break;
            drive(1'b0, 2'd0, 12'd0, 36'd0, 1'b1);
        end
        check("drain_empty", 64'(empty), 64'(1));
    endtask

    // Mostly legal traffic with occasional reserved ops, bad cores and bad addresses.
    task automatic rand_cycle();
        logic [35:0] a;
        logic [1:0]  op;
        logic [11:0] core;
        a    = rand_addr();
        op   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        core = 12'($urandom_range(0, 12));
        if ($urandom_range(0, 9) == 0) a[6] = 1'b1;
        drive(1'($urandom_range(0, 1)), op, core, a, 1'($urandom_range(0, 1)));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [35:0] a17;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 2'd0;
        in_core   = 12'd0;
        in_addr   = 36'd0;
        out_ready = 1'b0;
        @(negedge clk);
        #1;

        // Offers during reset must be ignored.
        repeat (3) drive(1'b1, 2'd0, 12'd3, 36'h012345638, 1'b0);
        check("rst_count",     64'(count),     64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_empty",     64'(empty),     64'(1));
        check("rst_full",      64'(full),      64'(0));
        rst_n = 1'b1;

        // Single known request and its decode.
        drive(1'b1, 2'd0, 12'd3, 36'h012345638, 1'b0);
        check("dir_valid", 64'(out_valid), 64'(1));
        check("dir_row",   64'(out_row),   64'h048D);
        check("dir_col",   64'(out_col),   64'h05E);
        check("dir_bank",  64'(out_bank),  64'(1));
        check("dir_bg",    64'(out_bg),    64'(4));
        check("dir_count", 64'(count),     64'(1));
        drive(1'b0, 2'd0, 12'd0, 36'd0, 1'b1);

        // Fill to capacity; a 17th offer is held until a slot frees up.
        for (int i = 0; i < DEPTH; i++) push_legal(1'b0);
        check("fill_full",     64'(full),     64'(1));
        check("fill_in_ready", 64'(in_ready), 64'(0));
        a17 = rand_addr();
        drive(1'b1, 2'd1, 12'd5, a17, 1'b0);
        drive(1'b1, 2'd1, 12'd5, a17, 1'b0);
        check("held_count", 64'(count), 64'(DEPTH));
        drive(1'b1, 2'd1, 12'd5, a17, 1'b1);
        check("no_passthru_count", 64'(count), 64'(DEPTH - 1));
        drive(1'b1, 2'd1, 12'd5, a17, 1'b0);
        check("accept17_count", 64'(count), 64'(DEPTH));
        drain();

        // Illegal offers: each is dropped with a single-cycle error pulse.
        for (int i = 0; i < 3; i++) push_legal(1'b0);
        drive(1'b1, 2'd3, 12'd1, rand_addr(), 1'b0);
        check("ill_op_err",   64'(err_illegal), 64'(1));
        check("ill_op_count", 64'(count),       64'(3));
        idle(1);
        check("ill_pulse_end", 64'(err_illegal), 64'(0));
        drive(1'b1, 2'd0, 12'd12, rand_addr(), 1'b0);
        check("ill_core_err",   64'(err_illegal), 64'(1));
        check("ill_core_count", 64'(count),       64'(3));
        idle(1);
        drive(1'b1, 2'd0, 12'd1, 36'h012345678, 1'b0);
        check("ill_addr_err",   64'(err_illegal), 64'(1));
        check("ill_addr_count", 64'(count),       64'(3));
        idle(1);

        // Simultaneous push and pop at count 5.
        push_legal(1'b0);
        push_legal(1'b0);
        push_legal(1'b1);
        check("pushpop_count", 64'(count), 64'(5));

        // Mixed traffic long enough to wrap both pointers.
        for (int i = 0; i < 40; i++) rand_cycle();
        drain();

        // Age saturation on a long-held head, then the next head's own residency.
        push_legal(1'b0);
        idle(200);
        push_legal(1'b0);
        idle(100);
        check("age_sat", 64'(out_age), 64'(AGE_MAX));
        drive(1'b0, 2'd0, 12'd0, 36'd0, 1'b1);
        check("age_next_head", 64'(out_age), 64'(101));
        drain();

        // Random soak.
        for (int i = 0; i < 300; i++) rand_cycle();

        // Asynchronous reset while holding entries discards them at once.
        for (int i = 0; i < 4; i++) push_legal(1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_count", 64'(count),     64'(0));
        check("midrst_valid", 64'(out_valid), 64'(0));
        idle(2);
        rst_n = 1'b1;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
